// File: rtl/phase_timer.sv
// phase_timer -- per-phase countdown for a traffic light sequencer.
//
// The timer watches the lamp outputs of a downstream light sequencer,
// works out which phase is showing, counts that phase's duration in
// one-second ticks and then emits a single-cycle advance pulse (en).
// It also debounces a raw pedestrian push-button and turns each accepted
// press into a single-cycle request pulse (ped_toggle).
//
// Ports
//   clk           : system clock, rising edge
//   reset         : asynchronous, active-high reset
//   ped_btn       : raw asynchronous pedestrian button, high = pressed
//   hold          : freezes the countdown while high (COUNT state only)
//   MG,MY,MR      : main-road lamp outputs of the sequencer
//   SG,SY,SR      : side-road lamp outputs of the sequencer
//   ped_light     : pedestrian lamp output of the sequencer
//   en            : registered one-cycle advance pulse to the sequencer
//   ped_toggle    : registered one-cycle pedestrian request pulse
//   sec_remaining : registered ticks left in the current phase
//
// Pulse semantics: en and ped_toggle are fire-and-forget strobes with no
// back-pressure; each is high for exactly one clk cycle and the receiver
// must act on it in that cycle.
module phase_timer #(
    parameter int TICK_DIV        = 50000000,
    parameter int GREEN_S         = 10,
    parameter int YELLOW_S        = 3,
    parameter int ALLRED_S        = 2,
    parameter int PED_S           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_btn,
    input  logic       hold,
    input  logic       MG,
    input  logic       MY,
    input  logic       MR,
    input  logic       SG,
    input  logic       SY,
    input  logic       SR,
    input  logic       ped_light,
    output logic       en,
    output logic       ped_toggle,
    output logic [7:0] sec_remaining
);

    // Durations are 8-bit; a zero duration is treated as one tick.
    localparam logic [7:0] GREEN_D  = (GREEN_S  % 256 == 0) ? 8'd1 : 8'(GREEN_S  % 256);
    localparam logic [7:0] YELLOW_D = (YELLOW_S % 256 == 0) ? 8'd1 : 8'(YELLOW_S % 256);
    localparam logic [7:0] ALLRED_D = (ALLRED_S % 256 == 0) ? 8'd1 : 8'(ALLRED_S % 256);
    localparam logic [7:0] PED_D    = (PED_S    % 256 == 0) ? 8'd1 : 8'(PED_S    % 256);

    localparam int                 PRE_W   = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]   PRE_TOP = PRE_W'(TICK_DIV - 1);
    localparam int                 DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]    DB_MAX  = DB_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        PH_ALLRED = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_PED    = 2'd3
    } phaseT;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2,
        WAIT  = 2'd3
    } stateT;

    stateT            state;
    phaseT            curPhase;
    phaseT            decPhase;
    logic [7:0]       decDur;
    logic [PRE_W-1:0] prescaler;
    logic [7:0]       secCnt;
    logic [1:0]       waitCnt;

    logic             syncA;
    logic             syncB;
    logic             debLevel;
    logic             debLevelQ;
    logic [DB_W-1:0]  dbCnt;

    // Red lamps carry no information the decode needs: a phase with no
    // green, yellow or pedestrian lamp lit is all-red regardless.
    logic unusedRedLamps;
    assign unusedRedLamps = MR ^ SR;

    // Phase decode, highest priority first. Any lamp pattern that is not
    // recognised (including illegal ones) falls through to all-red.
    always_comb begin
        decPhase = PH_ALLRED;
        decDur   = ALLRED_D;
        if (ped_light) begin
            decPhase = PH_PED;
            decDur   = PED_D;
        end else if (MG | SG) begin
            decPhase = PH_GREEN;
            decDur   = GREEN_D;
        end else if (MY | SY) begin
            decPhase = PH_YELLOW;
            decDur   = YELLOW_D;
        end
    end

    // Countdown FSM. sec_remaining is written alongside every transition so
    // it always reflects the state being entered: secCnt+1 in COUNT, 0 else.
    // secCnt never exceeds 254, so secCnt+1 stays within the 8-bit range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= LOAD;
            curPhase      <= PH_ALLRED;
            prescaler     <= '0;
            secCnt        <= 8'd0;
            waitCnt       <= 2'd0;
            en            <= 1'b0;
            sec_remaining <= 8'd0;
        end else begin
            en <= 1'b0;
            case (state)
                LOAD: begin
                    curPhase      <= decPhase;
                    secCnt        <= decDur - 8'd1;
                    prescaler     <= '0;
                    sec_remaining <= decDur;
                    state         <= COUNT;
                end
                COUNT: begin
                    // A lamp change wins over hold and over a coincident tick.
                    if (decPhase != curPhase) begin
                        sec_remaining <= 8'd0;
                        state         <= LOAD;
                    end else if (!hold) begin
                        if (prescaler == PRE_TOP) begin
                            prescaler <= '0;
                            if (secCnt == 8'd0) begin
                                en            <= 1'b1;
                                sec_remaining <= 8'd0;
                                state         <= FIRE;
                            end else begin
                                secCnt        <= secCnt - 8'd1;
                                sec_remaining <= secCnt;
                            end
                        end else begin
                            prescaler <= prescaler + PRE_W'(1);
                        end
                    end
                end
                FIRE: begin
                    waitCnt <= 2'd0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // Retime the same phase if the sequencer does not react
                    // to en within four cycles.
                    if ((decPhase != curPhase) || (waitCnt == 2'd3)) begin
                        state <= LOAD;
                    end else begin
                        waitCnt <= waitCnt + 2'd1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Button path: two-flop synchroniser, then a debouncer that commits a
    // new level on the edge after DEBOUNCE_CYCLES consecutive disagreeing
    // cycles have been counted. Any agreeing cycle restarts the count.
    // A rise seen while the pedestrian lamp is lit is dropped outright.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncA      <= 1'b0;
            syncB      <= 1'b0;
            debLevel   <= 1'b0;
            debLevelQ  <= 1'b0;
            dbCnt      <= '0;
            ped_toggle <= 1'b0;
        end else begin
            syncA <= ped_btn;
            syncB <= syncA;
            if (syncB != debLevel) begin
                if (dbCnt == DB_MAX) begin
                    debLevel <= syncB;
                    dbCnt    <= '0;
                end else begin
                    dbCnt <= dbCnt + DB_W'(1);
                end
            end else begin
                dbCnt <= '0;
            end
            debLevelQ  <= debLevel;
            ped_toggle <= debLevel & ~debLevelQ & ~ped_light;
        end
    end

endmodule
